// File: rtl/main_mem_responder.sv
// Main-memory responder: queues L2 fill/writeback requests and answers each
// one after a fixed latency, oldest first, with saturating traffic counters.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  S_IDLE | nothing in flight; start timing as soon as the queue has work
//  S_WAIT | latency timer counting down for the queue head
//  S_RESP | head presented on resp_*, held until L2 accepts it
module main_mem_responder #(
    parameter int LATENCY    = 4,
    parameter int DEPTH      = 4,
    parameter int BLOCK_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [47:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_op,
    output logic [47:0] resp_addr,
    output logic [11:0] mem_reads,
    output logic [11:0] mem_writes,
    output logic        busy
);

    localparam int          PW       = $clog2(DEPTH);
    localparam int          CW       = PW + 1;
    localparam logic [3:0]  LAT_M1   = 4'(LATENCY - 1);
    localparam logic [47:0] BLK_MASK = ~((48'd1 << BLOCK_BITS) - 48'd1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q;
    logic [3:0]    lat_q;
    logic [11:0]   reads_q;
    logic [11:0]   writes_q;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          op_mem   [DEPTH];
    logic [47:0]   addr_mem [DEPTH];

    logic          push;
    logic          pop;
    logic          head_op;
    logic [47:0]   head_addr;

    // No bypass: a full queue refuses even when the head pops this cycle.
    assign req_ready = (count_q < CW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == S_RESP) && resp_ready;
    assign head_op   = op_mem[rd_ptr_q];
    assign head_addr = addr_mem[rd_ptr_q];

    assign resp_valid = (state_q == S_RESP);
    assign resp_op    = resp_valid && head_op;
    assign resp_addr  = resp_valid ? head_addr : 48'd0;
    assign mem_reads  = reads_q;
    assign mem_writes = writes_q;
    assign busy       = (count_q != '0) || (state_q != S_IDLE);

    // Next queue pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Queue storage; address is block-aligned on the way in.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            op_mem[wr_ptr_q]   <= req_op;
            addr_mem[wr_ptr_q] <= req_addr & BLK_MASK;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sequencer. The timer starts on the edge that makes work available
    // (a push into an idle queue, or the handshake that exposes the next
    // entry) so a response appears exactly LATENCY edges later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            lat_q    <= 4'd0;
            reads_q  <= 12'd0;
            writes_q <= 12'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if ((count_q != '0) || push) begin
                        state_q <= S_WAIT;
                        lat_q   <= LAT_M1;
                    end
                end
                S_WAIT: begin
                    if (lat_q == 4'd0) begin
                        state_q <= S_RESP;
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        if (head_op) begin
                            if (writes_q != 12'hFFF) writes_q <= writes_q + 12'd1;
                        end else begin
                            if (reads_q != 12'hFFF) reads_q <= reads_q + 12'd1;
                        end
                        if ((count_q > CW'(1)) || push) begin
                            state_q <= S_WAIT;
                            lat_q   <= LAT_M1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// Scoreboard bench for main_mem_responder: accepted requests go into an
// expected-response queue; a negedge monitor checks every presented response
// for content, FIFO order, start time and stability, plus the counters.
module tb_main_mem_responder;

    localparam int L  = 4;
    localparam int D  = 4;
    localparam int BB = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_op = 1'b0;
    logic [47:0] req_addr = 48'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_op;
    logic [47:0] resp_addr;
    logic [11:0] mem_reads;
    logic [11:0] mem_writes;
    logic        busy;

    main_mem_responder #(.LATENCY(L), .DEPTH(D), .BLOCK_BITS(BB)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op), .resp_addr(resp_addr),
        .mem_reads(mem_reads), .mem_writes(mem_writes), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        op;
        logic [47:0] addr;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          model_reads = 0;
    int          model_writes = 0;
    int          last_hs = -1000;
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic        prev_op = 1'b0;
    logic [47:0] prev_addr = 48'd0;
    logic        rand_rr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [47:0] align(input logic [47:0] a);
        return (a >> BB) << BB;
    endfunction

    // Monitor: inputs only change just after posedge, so at negedge the
    // handshake signals are exactly what the coming edge will sample.
    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            model_reads  = 0;
            model_writes = 0;
            last_hs      = -1000;
            prev_valid   = 1'b0;
            prev_hs      = 1'b0;
        end else begin
            chk("mem_reads", 64'(mem_reads), 64'(model_reads));
            chk("mem_writes", 64'(mem_writes), 64'(model_writes));
            if (resp_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_resp", 64'(resp_valid), 64'd0);
                end else begin
                    if (!prev_valid || prev_hs) begin
                        chk("resp_start_edge", 64'(cyc),
                            64'(((q[0].acc > last_hs) ? q[0].acc : last_hs) + L));
                    end else begin
                        chk("stable_op", 64'(resp_op), 64'(prev_op));
                        chk("stable_addr", 64'(resp_addr), 64'(prev_addr));
                    end
                    chk("resp_op", 64'(resp_op), 64'(q[0].op));
                    chk("resp_addr", 64'(resp_addr), 64'(q[0].addr));
                end
            end else begin
                if (resp_op !== 1'b0 || resp_addr !== 48'd0)
                    chk("idle_resp_zero", {15'd0, resp_op, resp_addr}, 64'd0);
            end
            prev_hs = resp_valid && resp_ready;
            if (prev_hs && q.size() != 0) begin
                if (q[0].op) begin
                    if (model_writes < 4095) model_writes++;
                end else begin
                    if (model_reads < 4095) model_reads++;
                end
                void'(q.pop_front());
                last_hs = cyc + 1;
            end
            if (req_valid && req_ready) begin
                exp_t e;
                e.op   = req_op;
                e.addr = align(req_addr);
                e.acc  = cyc + 1;
                q.push_back(e);
            end
            prev_valid = resp_valid;
            prev_op    = resp_op;
            prev_addr  = resp_addr;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sync();
        reset = 1'b1;
    endtask

    // Present one request and hold it until accepted; acc is the accept edge.
    task automatic send(input logic op, input logic [47:0] addr, output int acc);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        acc       = -1;
        while (acc < 0 && n < 300) begin
            @(negedge clk);
            if (req_ready && reset) begin
                @(posedge clk);
                #1;
                acc = cyc;
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        req_valid = 1'b0;
        if (acc < 0) chk("req_accept_timeout", 64'(n), 64'd0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q.size() != 0 || resp_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("drain_timeout", 64'(q.size()), 64'd0);
        sync();
    endtask

    initial begin
        int acc;
        int acc5;
        int n;

        fork
            forever begin
                @(posedge clk);
                #1;
                if (rand_rr) resp_ready = ($urandom_range(0, 9) < 7);
            end
        join_none

        // Reset state
        repeat (3) sync();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_addr", 64'(resp_addr), 64'd0);
        chk("rst_mem_reads", 64'(mem_reads), 64'd0);
        sync();

        // Single read, exact latency and aligned address
        resp_ready = 1'b1;
        send(1'b0, 48'h7fff493822b8, acc);
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("single_latency", 64'(cyc), 64'(acc + L));
        chk("single_addr", 64'(resp_addr), 64'h7fff49382280);
        chk("single_op", 64'(resp_op), 64'd0);
        drain(100);
        @(negedge clk);
        chk("single_reads", 64'(mem_reads), 64'd1);
        sync();

        // Fill to DEPTH with resp_ready low, fifth request held off
        resp_ready = 1'b0;
        for (int i = 0; i < D; i++) send(i[0], {$urandom, $urandom}, acc);
        @(negedge clk);
        chk("full_req_ready", 64'(req_ready), 64'd0);
        sync();
        fork
            begin
                send(1'b1, 48'h123456789abc, acc5);
                chk("fifth_accept_edge", 64'(acc5), 64'(last_hs + 1));
            end
            begin
                repeat (12) @(negedge clk);
                chk("held_busy", 64'(busy), 64'd1);
                chk("held_valid", 64'(resp_valid), 64'd1);
                chk("held_reads", 64'(mem_reads), 64'd1);
                sync();
                resp_ready = 1'b1;
            end
        join
        drain(200);

        // Write then read back-to-back
        do_reset();
        resp_ready = 1'b1;
        send(1'b1, 48'h0000006324d8, acc);
        send(1'b0, 48'h7f3035f6a7c0, acc);
        drain(100);
        @(negedge clk);
        chk("wr_rd_writes", 64'(mem_writes), 64'd1);
        chk("wr_rd_reads", 64'(mem_reads), 64'd1);
        sync();

        // Reset while waiting with three entries queued; requests during reset ignored
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, {$urandom, $urandom}, acc);
        reset     = 1'b0;
        req_valid = 1'b1;
        req_addr  = 48'hdeadbeef0040;
        sync();
        reset     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_reads", 64'(mem_reads), 64'd0);
        chk("mid_rst_writes", 64'(mem_writes), 64'd0);
        sync();
        resp_ready = 1'b1;
        repeat (20) sync();

        // Random traffic with random backpressure
        rand_rr = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(1'($urandom_range(0, 1)), {$urandom, $urandom}, acc);
            repeat ($urandom_range(0, 3)) sync();
        end
        rand_rr    = 1'b0;
        sync();
        resp_ready = 1'b1;
        drain(3000);

        // Read counter saturation
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 4100; i++) send(1'b0, {$urandom, $urandom}, acc);
        drain(1000);
        @(negedge clk);
        chk("sat_reads", 64'(mem_reads), 64'hFFF);
        chk("sat_writes", 64'(mem_writes), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
